// File: rtl/jtdd_hshift_pkg.sv
// Shared defaults and constants for the horizontal-shift line buffer.
package jtdd_hshift_pkg;

    localparam int AW_DEF   = 8;   // log2 of line buffer depth (256 pixels)
    localparam int DW_DEF   = 12;  // {red, green, blue}, 4 bits each
    localparam int OFFW_DEF = 5;   // signed horizontal offset, -16..+15

    // Number of pxl_cen cycles between the read counter and the RGB outputs;
    // every sync delay line must match this.
    localparam int PIPE_DEPTH = 2;

    localparam logic [DW_DEF-1:0] BLACK_PXL = '0;

    // One slot of the sync/blanking delay line.
    typedef struct packed {
        logic lhbl;
        logic lvbl;
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/jtdd_hshift_ram.sv
// Ping-pong line memory: two banks of 2^AW pixels, bank selected by the
// address MSB. Writes and the registered read both advance on cen_i only.
module jtdd_hshift_ram
    import jtdd_hshift_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_i,
    input  logic          we_i,
    input  logic [AW:0]   waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW:0]   raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem [0:(2**(AW+1))-1];
    logic [DW-1:0] rdata_q;

    // Pixel write into the bank currently being captured.
    // NOTE: the memory array has no reset so it maps onto block RAM; the
    // per-bank valid flags in the parent keep stale contents off screen.
    always_ff @(posedge clk) begin
        if (cen_i && we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Registered read of the bank being replayed.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (cen_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/jtdd_hshift.sv
// Line-buffer stage: captures each active line into one bank and replays the
// previous line from the other bank, shifted by a signed pixel offset.
// Lines shorter than 2^AW leave a stale tail that is replayed as-is; a partial
// line following reset release is never captured.
module jtdd_hshift
    import jtdd_hshift_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int OFFW = OFFW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pxl_cen,
    input  logic [3:0]      red,
    input  logic [3:0]      green,
    input  logic [3:0]      blue,
    input  logic            LHBL,
    input  logic            LVBL,
    input  logic            HS,
    input  logic            VS,
    input  logic [OFFW-1:0] hoffset,
    output logic [3:0]      red_o,
    output logic [3:0]      green_o,
    output logic [3:0]      blue_o,
    output logic            LHBL_o,
    output logic            LVBL_o,
    output logic            HS_o,
    output logic            VS_o
);

    localparam logic [AW-1:0] CNT_MAX = '1;
    localparam logic [DW-1:0] BLACK   = DW'(BLACK_PXL);

    // Line control state
    logic            lhbl_prev_q;
    logic            armed_q;      // a blank has been seen since reset
    logic            line_wr_q;    // this line has been captured from pixel 0
    logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            wr_full_q, wr_full_d;
    logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            bank_q;
    logic [1:0]      valid_q;
    logic [OFFW-1:0] hoff_q;
    logic            lvbl_line_q, vs_line_q;

    // Pipeline and delay line
    sync_t [PIPE_DEPTH-1:0] sync_dly_q;
    sync_t           sync_in;
    logic            rd_ok_q;
    logic [DW-1:0]   rgb_q;
    logic [DW-1:0]   ram_rdata;

    // Combinational helpers
    logic            lhbl_rise, lhbl_fall;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [AW:0]     src;
    logic            src_in_range;

    // A rise only counts once a blank was seen, so a line cut by reset is skipped.
    assign lhbl_rise = LHBL & ~lhbl_prev_q & armed_q;
    assign lhbl_fall = ~LHBL & lhbl_prev_q;

    assign wr_en   = LHBL & (lhbl_rise | (line_wr_q & ~wr_full_q));
    assign wr_addr = lhbl_rise ? '0 : wr_cnt_q;

    // Source index; sources below 0 or above 2^AW-1 both land with the MSB set.
    assign src          = {1'b0, rd_cnt_q} - {{(AW+1-OFFW){hoff_q[OFFW-1]}}, hoff_q};
    assign src_in_range = ~src[AW];

    // Next-state for the saturating write and read counters.
    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_full_d = wr_full_q;
        rd_cnt_d  = rd_cnt_q;
        if (wr_en) begin
            wr_cnt_d  = (wr_addr == CNT_MAX) ? wr_addr : wr_addr + AW'(1);
            wr_full_d = (wr_addr == CNT_MAX);
        end
        if (lhbl_fall) begin
            rd_cnt_d = '0;
        end else if (LHBL && rd_cnt_q != CNT_MAX) begin
            rd_cnt_d = rd_cnt_q + AW'(1);
        end
    end

    // Counters, bank swap and per-line sampled values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhbl_prev_q <= 1'b0;
            armed_q     <= 1'b0;
            line_wr_q   <= 1'b0;
            wr_cnt_q    <= '0;
            wr_full_q   <= 1'b0;
            rd_cnt_q    <= '0;
            bank_q      <= 1'b0;
            valid_q     <= '0;
            hoff_q      <= '0;
            lvbl_line_q <= 1'b0;
            vs_line_q   <= 1'b0;
        end else if (pxl_cen) begin
            lhbl_prev_q <= LHBL;
            wr_cnt_q    <= wr_cnt_d;
            wr_full_q   <= wr_full_d;
            rd_cnt_q    <= rd_cnt_d;
            if (!LHBL) begin
                armed_q <= 1'b1;
            end
            if (lhbl_rise) begin
                line_wr_q <= 1'b1;
            end else if (lhbl_fall) begin
                line_wr_q <= 1'b0;
            end
            if (lhbl_fall) begin
                valid_q[bank_q] <= line_wr_q;
                bank_q          <= ~bank_q;
                hoff_q          <= hoffset;
                lvbl_line_q     <= LVBL;
                vs_line_q       <= VS;
            end
        end
    end

    jtdd_hshift_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen_i   (pxl_cen),
        .we_i    (wr_en),
        .waddr_i ({bank_q, wr_addr}),
        .wdata_i ({red, green, blue}),
        .raddr_i ({~bank_q, src[AW-1:0]}),
        .rdata_o (ram_rdata)
    );

    assign sync_in = '{lhbl: LHBL, lvbl: lvbl_line_q, hs: HS, vs: vs_line_q};

    // Sync/blanking delay line, matched to the RGB pipeline depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_dly_q <= '0;
        end else if (pxl_cen) begin
            sync_dly_q <= {sync_dly_q[PIPE_DEPTH-2:0], sync_in};
        end
    end

    // Stage 1 flags alongside the RAM read; stage 2 muxes to black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ok_q <= 1'b0;
            rgb_q   <= '0;
        end else if (pxl_cen) begin
            rd_ok_q <= LHBL & src_in_range & valid_q[~bank_q];
            rgb_q   <= rd_ok_q ? ram_rdata : BLACK;
        end
    end

    assign red_o   = rgb_q[11:8];
    assign green_o = rgb_q[7:4];
    assign blue_o  = rgb_q[3:0];
    assign LHBL_o  = sync_dly_q[PIPE_DEPTH-1].lhbl;
    assign LVBL_o  = sync_dly_q[PIPE_DEPTH-1].lvbl;
    assign HS_o    = sync_dly_q[PIPE_DEPTH-1].hs;
    assign VS_o    = sync_dly_q[PIPE_DEPTH-1].vs;

endmodule

// File: tb/tb_jtdd_hshift.sv
// Directed bench for jtdd_hshift: whole lines are driven with pxl_cen every
// other clock; each output line is compared pixel by pixel with a small model
// of the previous line, plus hand-computed spot values.
module tb_jtdd_hshift;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pxl_cen = 1'b0;
    logic [3:0] red = '0, green = '0, blue = '0;
    logic       LHBL = 1'b0, LVBL = 1'b0, HS = 1'b0, VS = 1'b0;
    logic [4:0] hoffset = '0;
    logic [3:0] red_o, green_o, blue_o;
    logic       LHBL_o, LVBL_o, HS_o, VS_o;

    jtdd_hshift dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pxl_cen (pxl_cen),
        .red     (red),
        .green   (green),
        .blue    (blue),
        .LHBL    (LHBL),
        .LVBL    (LVBL),
        .HS      (HS),
        .VS      (VS),
        .hoffset (hoffset),
        .red_o   (red_o),
        .green_o (green_o),
        .blue_o  (blue_o),
        .LHBL_o  (LHBL_o),
        .LVBL_o  (LVBL_o),
        .HS_o    (HS_o),
        .VS_o    (VS_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Capture of the current output line
    logic [11:0] cap [0:511];
    int          opos;
    logic        lho_prev;
    logic        cap_lvbl, cap_vs;
    int          nz;
    int          sync_bad;
    logic        prev_lh, prev_hs;

    // Line-level stimulus state
    logic       cur_lvbl, cur_vs;
    logic [4:0] cur_h;

    // Model of the line stored in the replay bank
    logic       mdl_valid;
    logic [3:0] mdl_tag;
    int         mdl_len;
    int         mdl_h;
    logic       mdl_lvbl, mdl_vs;

    function automatic logic [11:0] pix(input logic [3:0] tag, input int k);
        logic [7:0] lo;
        lo = k[7:0];
        return (k < 256) ? {tag, lo} : {~tag, lo};
    endfunction

    function automatic logic [11:0] exp_px(input int j);
        int rd, src;
        rd  = (j > 255) ? 255 : j;
        src = rd - mdl_h;
        if (!mdl_valid || src < 0 || src > 255 || src >= mdl_len) return 12'h000;
        return pix(mdl_tag, src);
    endfunction

    task automatic sample_cen();
        logic [11:0] rgb;
        rgb = {red_o, green_o, blue_o};
        if (LHBL_o !== prev_lh || HS_o !== prev_hs) sync_bad++;
        if (LHBL_o === 1'b1) begin
            if (!lho_prev) opos = 0;
            if (opos < 512) cap[opos] = rgb;
            if (opos == 10) begin
                cap_lvbl = LVBL_o;
                cap_vs   = VS_o;
            end
            opos++;
        end else if (rgb !== 12'h000) begin
            sync_bad++;
        end
        if (rgb !== 12'h000) nz++;
        lho_prev = LHBL_o;
    endtask

    // One pixel: a pxl_cen clock, then an idle clock with scrambled inputs.
    task automatic step(input logic lh, input logic hs, input logic [11:0] rgb);
        logic [15:0] snap;
        @(negedge clk);
        pxl_cen = 1'b1;
        LHBL = lh; HS = hs; {red, green, blue} = rgb;
        LVBL = cur_lvbl; VS = cur_vs; hoffset = cur_h;
        @(posedge clk); #1;
        sample_cen();
        prev_lh = lh;
        prev_hs = hs;
        snap = {red_o, green_o, blue_o, LHBL_o, LVBL_o, HS_o, VS_o};
        @(negedge clk);
        pxl_cen = 1'b0;
        LHBL = ~lh; HS = ~hs; {red, green, blue} = ~rgb;
        @(posedge clk); #1;
        if ({red_o, green_o, blue_o, LHBL_o, LVBL_o, HS_o, VS_o} !== snap) sync_bad++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        pxl_cen = 1'b0;
        #1;
        checks++;
        if ({red_o, green_o, blue_o, LHBL_o, LVBL_o, HS_o, VS_o} !== 16'h0000)
            $display("FAIL midline_reset_clear: got %h required 0000",
                     {red_o, green_o, blue_o, LHBL_o, LVBL_o, HS_o, VS_o});
        if ({red_o, green_o, blue_o, LHBL_o, LVBL_o, HS_o, VS_o} !== 16'h0000) errors++;
        @(negedge clk);
        rst_n = 1'b1;
        prev_lh = 1'b0; prev_hs = 1'b0; lho_prev = 1'b0; nz = 0;
    endtask

    // 16 blank pixels (HS pulse inside), len active pixels, 4 trailing blanks.
    task automatic run_line(input string name, input logic [3:0] tag, input int len,
                            input logic [4:0] h, input logic do_mid, input logic [4:0] h_mid,
                            input logic lvbl, input logic vs, input int rst_at);
        int bad, first_bad;
        cur_lvbl = lvbl; cur_vs = vs; cur_h = h;
        opos = 0; nz = 0; sync_bad = 0; cap_lvbl = 1'bx; cap_vs = 1'bx;
        for (int i = 0; i < 16; i++) step(1'b0, (i >= 2 && i < 6), 12'h000);
        for (int k = 0; k < len; k++) begin
            if (k == rst_at) pulse_reset();
            if (do_mid && k == 128) cur_h = h_mid;
            step(1'b1, 1'b0, pix(tag, k));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 12'h000);
        if (rst_at < 0) begin
            checks++;
            if (opos != len) begin
                errors++;
                $display("FAIL %s_length: got %0d pixels required %0d", name, opos, len);
            end
            bad = 0; first_bad = -1;
            for (int j = 0; j < len; j++) begin
                if (cap[j] !== exp_px(j)) begin
                    if (first_bad < 0) first_bad = j;
                    bad++;
                end
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_pixels: %0d wrong, first at %0d got %h required %h",
                         name, bad, first_bad, cap[first_bad], exp_px(first_bad));
            end
            checks++;
            if (cap_lvbl !== mdl_lvbl || cap_vs !== mdl_vs) begin
                errors++;
                $display("FAIL %s_line_sync: got LVBL_o=%b VS_o=%b required %b %b",
                         name, cap_lvbl, cap_vs, mdl_lvbl, mdl_vs);
            end
        end else begin
            checks++;
            if (nz != 0) begin
                errors++;
                $display("FAIL %s_black_after_reset: got %0d lit pixels required 0", name, nz);
            end
        end
        checks++;
        if (sync_bad != 0) begin
            errors++;
            $display("FAIL %s_sync_delay: got %0d bad samples required 0", name, sync_bad);
        end
        mdl_valid = (rst_at < 0);
        mdl_tag   = tag;
        mdl_len   = (len > 256) ? 256 : len;
        mdl_h     = int'($signed(cur_h));
        mdl_lvbl  = lvbl;
        mdl_vs    = vs;
    endtask

    task automatic spot(input string name, input int pos, input logic [11:0] want);
        checks++;
        if (cap[pos] !== want) begin
            errors++;
            $display("FAIL %s: position %0d got %h required %h", name, pos, cap[pos], want);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({red_o, green_o, blue_o} !== 12'h000) begin
            errors++;
            $display("FAIL reset_rgb: got %h required 000", {red_o, green_o, blue_o});
        end
        checks++;
        if ({LHBL_o, LVBL_o, HS_o, VS_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sync: got %b required 0000", {LHBL_o, LVBL_o, HS_o, VS_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_first_lines();
        run_line("line0", 4'h0, 256, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL first_line_black: got %0d lit pixels required 0", nz);
        end
        run_line("line1", 4'h1, 256, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        spot("identity_100", 100, 12'h064);
        spot("identity_255", 255, 12'h0FF);
    endtask

    task automatic test_pos_shift();
        run_line("line2", 4'h2, 256, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, -1);
        run_line("line3", 4'h3, 256, 5'h10, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        spot("pos3_left_black", 2, 12'h000);
        spot("pos3_src0", 3, 12'h200);
        spot("pos3_last", 255, 12'h2FC);
        checks++;
        if (cap_lvbl !== 1'b0 || cap_vs !== 1'b1) begin
            errors++;
            $display("FAIL vblank_line_delay: got LVBL_o=%b VS_o=%b required 0 1", cap_lvbl, cap_vs);
        end
    endtask

    task automatic test_neg_shift();
        run_line("line4", 4'h4, 300, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        spot("neg16_first", 0, 12'h310);
        spot("neg16_239", 239, 12'h3FF);
        spot("neg16_240_black", 240, 12'h000);
        spot("neg16_255_black", 255, 12'h000);
    endtask

    task automatic test_overlong();
        run_line("line5", 4'h5, 256, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, -1);
        spot("overlong_entry0", 0, 12'h400);
        spot("overlong_entry255", 255, 12'h4FF);
        spot("midchange_unaffected", 128, 12'h480);
    endtask

    task automatic test_mid_hoffset();
        run_line("line6", 4'h6, 256, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        spot("shift5_black", 4, 12'h000);
        spot("shift5_src0", 5, 12'h500);
        spot("shift5_last", 255, 12'h5FA);
    endtask

    task automatic test_midline_reset();
        run_line("line7", 4'h7, 256, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 100);
        run_line("line8", 4'h8, 256, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL line_after_reset_black: got %0d lit pixels required 0", nz);
        end
        run_line("line9", 4'h9, 256, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, -1);
        spot("recovered_7", 7, 12'h807);
    endtask

    initial begin
        prev_lh = 1'b0; prev_hs = 1'b0; lho_prev = 1'b0;
        cur_lvbl = 1'b0; cur_vs = 1'b0; cur_h = '0;
        mdl_valid = 1'b0; mdl_tag = '0; mdl_len = 0; mdl_h = 0;
        mdl_lvbl = 1'b0; mdl_vs = 1'b0;
        test_reset();
        test_first_lines();
        test_pos_shift();
        test_neg_shift();
        test_overlong();
        test_mid_hoffset();
        test_midline_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
